// File: rtl/id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_stage : ID/EX pipeline register with EX-side forwarding/hazards    |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module id_ex_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            id_valid_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [REGW-1:0] id_rs1_i,
  input  logic [REGW-1:0] id_rs2_i,
  input  logic [REGW-1:0] id_rd_i,
  input  logic [3:0]      id_alu_op_i,
  input  logic            id_alu_src_i,
  input  logic            id_op1_pc_i,
  input  logic            id_reg_write_i,
  input  logic            id_mem_read_i,
  input  logic            id_mem_write_i,
  input  logic            id_branch_i,
  input  logic            exmem_reg_write_i,
  input  logic [REGW-1:0] exmem_rd_i,
  input  logic [XLEN-1:0] exmem_result_i,
  input  logic            memwb_reg_write_i,
  input  logic [REGW-1:0] memwb_rd_i,
  input  logic [XLEN-1:0] memwb_result_i,
  output logic            ex_valid_o,
  output logic [3:0]      ex_alu_op_o,
  output logic [XLEN-1:0] ex_op1_o,
  output logic [XLEN-1:0] ex_op2_o,
  output logic [XLEN-1:0] ex_store_data_o,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [REGW-1:0] ex_rd_o,
  output logic            ex_reg_write_o,
  output logic            ex_mem_read_o,
  output logic            ex_mem_write_o,
  output logic            ex_branch_o,
  output logic            load_use_stall_o
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [REGW-1:0] rs1_q, rs1_d;
  logic [REGW-1:0] rs2_q, rs2_d;
  logic [REGW-1:0] rd_q, rd_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            alu_src_q, alu_src_d;
  logic            op1_pc_q, op1_pc_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            branch_q, branch_d;

  logic            w_load_use;
  logic            w_bubble;
  logic            w_load;
  logic            w_exm_hit_rs1, w_exm_hit_rs2;
  logic            w_mwb_hit_rs1, w_mwb_hit_rs2;
  logic [XLEN-1:0] w_rs1_fwd, w_rs2_fwd;

  assign w_load_use = valid_q && mem_read_q && (rd_q != '0) && id_valid_i &&
                      ((rd_q == id_rs1_i) || (rd_q == id_rs2_i));

  assign w_bubble = flush_i || (!stall_i && w_load_use);
  assign w_load   = !flush_i && !stall_i && !w_load_use;

  // Index 0 is hardwired zero, so it never takes a forwarded value.
  assign w_exm_hit_rs1 = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs1_q);
  assign w_exm_hit_rs2 = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs2_q);
  assign w_mwb_hit_rs1 = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs1_q);
  assign w_mwb_hit_rs2 = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs2_q);

  always_comb begin
    w_rs1_fwd = rs1_data_q;
    if (w_exm_hit_rs1) begin
      w_rs1_fwd = exmem_result_i;
    end else if (w_mwb_hit_rs1) begin
      w_rs1_fwd = memwb_result_i;
    end
  end

  always_comb begin
    w_rs2_fwd = rs2_data_q;
    if (w_exm_hit_rs2) begin
      w_rs2_fwd = exmem_result_i;
    end else if (w_mwb_hit_rs2) begin
      w_rs2_fwd = memwb_result_i;
    end
  end

  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alu_op_d    = alu_op_q;
    alu_src_d   = alu_src_q;
    op1_pc_d    = op1_pc_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    branch_d    = branch_q;
    if (w_bubble) begin
      valid_d     = 1'b0;
      pc_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      alu_op_d    = '0;
      alu_src_d   = 1'b0;
      op1_pc_d    = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      branch_d    = 1'b0;
    end else if (w_load) begin
      valid_d     = id_valid_i;
      pc_d        = id_pc_i;
      rs1_data_d  = id_rs1_data_i;
      rs2_data_d  = id_rs2_data_i;
      imm_d       = id_imm_i;
      rs1_d       = id_rs1_i;
      rs2_d       = id_rs2_i;
      rd_d        = id_rd_i;
      alu_op_d    = id_alu_op_i;
      alu_src_d   = id_alu_src_i;
      op1_pc_d    = id_op1_pc_i;
      reg_write_d = id_reg_write_i;
      mem_read_d  = id_mem_read_i;
      mem_write_d = id_mem_write_i;
      branch_d    = id_branch_i;
    end else begin
      // Holding: a writeback retiring now would otherwise be lost once MEM/WB moves on.
      if (w_mwb_hit_rs1) rs1_data_d = memwb_result_i;
      if (w_mwb_hit_rs2) rs2_data_d = memwb_result_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_op_q    <= '0;
      alu_src_q   <= 1'b0;
      op1_pc_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_op_q    <= alu_op_d;
      alu_src_q   <= alu_src_d;
      op1_pc_q    <= op1_pc_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      branch_q    <= branch_d;
    end
  end

  assign ex_valid_o       = valid_q;
  assign ex_alu_op_o      = alu_op_q;
  assign ex_op1_o         = op1_pc_q ? pc_q : w_rs1_fwd;
  assign ex_op2_o         = alu_src_q ? imm_q : w_rs2_fwd;
  assign ex_store_data_o  = w_rs2_fwd;
  assign ex_pc_o          = pc_q;
  assign ex_imm_o         = imm_q;
  assign ex_rd_o          = rd_q;
  assign ex_reg_write_o   = reg_write_q;
  assign ex_mem_read_o    = mem_read_q;
  assign ex_mem_write_o   = mem_write_q;
  assign ex_branch_o      = branch_q;
  assign load_use_stall_o = w_load_use;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_id_ex_stage : self-checking bench for id_ex_stage                     |
// | Revision       : 1.0                                                     |
// +--------------------------------------------------------------------------+
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [3:0]  id_alu_op;
  logic        id_alu_src, id_op1_pc, id_reg_write, id_mem_read, id_mem_write, id_branch;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, load_use_stall;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_op1, ex_op2, ex_store_data, ex_pc, ex_imm;
  logic [4:0]  ex_rd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .REGW(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .flush_i(flush), .id_valid_i(id_valid),
    .id_pc_i(id_pc), .id_rs1_data_i(id_rs1_data), .id_rs2_data_i(id_rs2_data),
    .id_imm_i(id_imm), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rd_i(id_rd),
    .id_alu_op_i(id_alu_op), .id_alu_src_i(id_alu_src), .id_op1_pc_i(id_op1_pc),
    .id_reg_write_i(id_reg_write), .id_mem_read_i(id_mem_read),
    .id_mem_write_i(id_mem_write), .id_branch_i(id_branch),
    .exmem_reg_write_i(exmem_reg_write), .exmem_rd_i(exmem_rd), .exmem_result_i(exmem_result),
    .memwb_reg_write_i(memwb_reg_write), .memwb_rd_i(memwb_rd), .memwb_result_i(memwb_result),
    .ex_valid_o(ex_valid), .ex_alu_op_o(ex_alu_op), .ex_op1_o(ex_op1), .ex_op2_o(ex_op2),
    .ex_store_data_o(ex_store_data), .ex_pc_o(ex_pc), .ex_imm_o(ex_imm), .ex_rd_o(ex_rd),
    .ex_reg_write_o(ex_reg_write), .ex_mem_read_o(ex_mem_read),
    .ex_mem_write_o(ex_mem_write), .ex_branch_o(ex_branch),
    .load_use_stall_o(load_use_stall)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        src, op1pc, rw;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        mw;
    logic [4:0]  mrd;
    logic [31:0] mres;
    logic [31:0] e_op1, e_op2, e_st;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] op1, op2, st;
  } exp_t;

  vec_t tbl[8];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alu_op = 0; id_alu_src = 0;
    id_op1_pc = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_branch = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic apply(input vec_t v);
    id_valid = v.valid; id_pc = v.pc; id_rs1_data = v.rs1d; id_rs2_data = v.rs2d;
    id_imm = v.imm; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd; id_alu_op = v.op;
    id_alu_src = v.src; id_op1_pc = v.op1pc; id_reg_write = v.rw; id_mem_read = 0;
    exmem_reg_write = v.xw; exmem_rd = v.xrd; exmem_result = v.xres;
    memwb_reg_write = v.mw; memwb_rd = v.mrd; memwb_result = v.mres;
  endtask

  task automatic pop_and_compare(input string tag);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard_empty actual=0 required=1", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".valid"},  32'(ex_valid),     32'(e.valid));
      check({tag, ".alu_op"}, 32'(ex_alu_op),    32'(e.op));
      check({tag, ".rd"},     32'(ex_rd),        32'(e.rd));
      check({tag, ".rw"},     32'(ex_reg_write), 32'(e.rw));
      check({tag, ".op1"},    ex_op1,            e.op1);
      check({tag, ".op2"},    ex_op2,            e.op2);
      check({tag, ".store"},  ex_store_data,     e.st);
    end
  endtask

  initial begin
    // valid pc rs1d rs2d imm rs1 rs2 rd op src op1pc rw | xw xrd xres | mw mrd mres | op1 op2 store
    tbl[0] = '{1, 32'h100, 70, 50, 0, 1, 2, 10, 4'h0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 70, 50, 50};
    tbl[1] = '{1, 32'h104, 9, 32'h33, 32'hFFFFFFFC, 4, 6, 11, 4'h0, 1, 0, 1,
               0, 0, 0, 0, 0, 0, 9, 32'hFFFFFFFC, 32'h33};
    tbl[2] = '{1, 32'h200, 5, 7, 32'h10, 1, 0, 1, 4'h0, 1, 1, 1,
               0, 0, 0, 0, 0, 0, 32'h200, 32'h10, 7};
    tbl[3] = '{1, 32'h204, 1, 50, 0, 5, 2, 13, 4'h1, 0, 0, 1, 1, 5, 100, 1, 5, 200, 100, 50, 50};
    tbl[4] = '{1, 32'h208, 1, 50, 0, 5, 2, 13, 4'h1, 0, 0, 1, 0, 5, 100, 1, 5, 200, 200, 50, 50};
    tbl[5] = '{1, 32'h20C, 1, 50, 0, 0, 2, 13, 4'h1, 0, 0, 1, 1, 0, 100, 1, 0, 200, 1, 50, 50};
    tbl[6] = '{1, 32'h210, 2, 3, 4, 9, 8, 14, 4'h2, 1, 0, 1,
               1, 9, 32'h88, 1, 8, 32'h77, 32'h88, 4, 32'h77};
    tbl[7] = '{0, 32'h214, 32'hDEAD, 32'hBEEF, 0, 3, 4, 15, 4'h8, 0, 0, 0,
               0, 0, 0, 0, 0, 0, 32'hDEAD, 32'hBEEF, 32'hBEEF};

    idle_inputs();
    rst_n = 0;
    #2;
    check("reset.valid", 32'(ex_valid), 0);
    check("reset.op1", ex_op1, 0);
    check("reset.op2", ex_op2, 0);
    check("reset.rw", 32'(ex_reg_write), 0);
    check("reset.lus", 32'(load_use_stall), 0);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      sb.push_back('{tbl[i].valid, tbl[i].op, tbl[i].rd, tbl[i].rw,
                     tbl[i].e_op1, tbl[i].e_op2, tbl[i].e_st});
      @(posedge clk);
      #1;
      pop_and_compare($sformatf("vec%0d", i));
    end

    // Load followed by a dependent consumer.
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_mem_read = 1; id_reg_write = 1; id_rd = 3; id_rs1 = 1; id_rs2 = 2;
    @(posedge clk);
    #1;
    check("lu.ex_mem_read", 32'(ex_mem_read), 1);
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rs1 = 1; id_rs2 = 3; id_rd = 4; id_rs1_data = 11; id_rs2_data = 22;
    id_reg_write = 1;
    #1;
    check("lu.stall", 32'(load_use_stall), 1);
    id_valid = 0;
    #1;
    check("lu.stall_invalid_id", 32'(load_use_stall), 0);
    id_valid = 1;
    #1;
    sb.push_back('{0, 4'h0, 5'd0, 0, 32'd0, 32'd0, 32'd0});
    @(posedge clk);
    #1;
    pop_and_compare("lu.bubble");
    check("lu.stall_after", 32'(load_use_stall), 0);

    // Stall with a writeback to the held rs1 retiring during the hold.
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rs1 = 7; id_rs1_data = 1; id_rs2 = 2; id_rs2_data = 50;
    id_alu_op = 4'h3; id_rd = 12; id_reg_write = 1;
    @(negedge clk);
    stall = 1; id_rs1_data = 999; id_alu_op = 4'h5; id_rd = 20;
    memwb_reg_write = 1; memwb_rd = 7; memwb_result = 55;
    @(posedge clk);
    #1;
    check("stall.alu_op_held", 32'(ex_alu_op), 32'h3);
    check("stall.rd_held", 32'(ex_rd), 12);
    @(negedge clk);
    memwb_reg_write = 0; memwb_result = 0;
    @(posedge clk);
    #1;
    check("stall.valid_held", 32'(ex_valid), 1);
    check("stall.op1_refresh", ex_op1, 55);
    @(negedge clk);
    stall = 0;
    #1;
    check("stall.op1_released", ex_op1, 55);
    check("stall.op2", ex_op2, 50);

    // Flush wins over stall.
    @(negedge clk);
    stall = 1; flush = 1;
    @(posedge clk);
    #1;
    check("flush.valid", 32'(ex_valid), 0);
    check("flush.op1", ex_op1, 0);
    check("flush.rw", 32'(ex_reg_write), 0);
    check("flush.rd", 32'(ex_rd), 0);

    // Asynchronous reset in the middle of a cycle while holding valid contents.
    @(negedge clk);
    idle_inputs();
    id_valid = 1; id_rs1_data = 32'h1234; id_rs2_data = 32'h5678; id_reg_write = 1; id_rd = 9;
    @(posedge clk);
    #1;
    check("async.pre_valid", 32'(ex_valid), 1);
    stall = 1;
    #2;
    rst_n = 0;
    #1;
    check("async.valid", 32'(ex_valid), 0);
    check("async.op1", ex_op1, 0);
    check("async.op2", ex_op2, 0);
    check("async.rw", 32'(ex_reg_write), 0);
    @(negedge clk);
    rst_n = 1;
    stall = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
